// File: rtl/led_pkg.sv
// Shared types for the status-LED driver: channel mode encoding and its legal upper bound.
package led_pkg;

    typedef enum logic [2:0] {
        LED_OFF     = 3'd0,
        LED_ON      = 3'd1,
        LED_BLINK   = 3'd2,
        LED_PWM     = 3'd3,
        LED_BREATHE = 3'd4
    } led_mode_t;

    localparam logic [2:0] LED_MODE_MAX = 3'd4;

endpackage

// File: rtl/led_channel.sv
// One LED channel: holds its configuration, blink and breathe state, and decides whether it is lit.
module led_channel
    import led_pkg::*;
#(
    parameter int PWM_BITS    = 8,
    parameter int PERIOD_BITS = 16
) (
    input  logic                   clk48,
    input  logic                   rst,
    input  logic                   we_i,
    input  logic                   tick_i,
    input  led_mode_t              mode_i,
    input  logic [PWM_BITS-1:0]    level_i,
    input  logic [PERIOD_BITS-1:0] half_per_i,
    input  logic [PWM_BITS-1:0]    pwm_cnt_i,
    output logic                   lit_o
);

    localparam logic [PWM_BITS-1:0]    B_ONE = PWM_BITS'(1);
    localparam logic [PERIOD_BITS-1:0] P_ONE = PERIOD_BITS'(1);

    led_mode_t               mode_q, mode_d;
    logic [PWM_BITS-1:0]     level_q, level_d;
    logic [PERIOD_BITS-1:0]  half_q, half_d;
    logic [PERIOD_BITS-1:0]  cnt_q, cnt_d;
    logic                    phase_q, phase_d;
    logic [PWM_BITS-1:0]     bright_q, bright_d;
    logic                    down_q, down_d;

    // Full-scale duty means always lit, so the top code is not lost to the strict compare.
    function automatic logic duty_lit(input logic [PWM_BITS-1:0] cnt,
                                      input logic [PWM_BITS-1:0] duty);
        return (cnt < duty) || (duty == '1);
    endfunction

    always_comb begin
        mode_d   = mode_q;
        level_d  = level_q;
        half_d   = half_q;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        bright_d = bright_q;
        down_d   = down_q;
        if (we_i) begin
            mode_d   = mode_i;
            level_d  = level_i;
            half_d   = (half_per_i == '0) ? P_ONE : half_per_i;
            cnt_d    = '0;
            phase_d  = 1'b0;
            bright_d = '0;
            down_d   = 1'b0;
        end else if (tick_i) begin
            if (mode_q == LED_BLINK) begin
                if (cnt_q == half_q - P_ONE) begin
                    cnt_d   = '0;
                    phase_d = ~phase_q;
                end else begin
                    cnt_d = cnt_q + P_ONE;
                end
            end
            // Level 0 pins bright at 0 instead of reversing around an empty range.
            if (mode_q == LED_BREATHE && level_q != '0) begin
                if (!down_q) begin
                    if (bright_q >= level_q) begin
                        down_d   = 1'b1;
                        bright_d = bright_q - B_ONE;
                    end else begin
                        bright_d = bright_q + B_ONE;
                    end
                end else if (bright_q == '0) begin
                    down_d   = 1'b0;
                    bright_d = B_ONE;
                end else begin
                    bright_d = bright_q - B_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk48) begin
        if (rst) begin
            mode_q   <= LED_OFF;
            level_q  <= '0;
            half_q   <= P_ONE;
            cnt_q    <= '0;
            phase_q  <= 1'b0;
            bright_q <= '0;
            down_q   <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            level_q  <= level_d;
            half_q   <= half_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            bright_q <= bright_d;
            down_q   <= down_d;
        end
    end

    always_comb begin
        case (mode_q)
            LED_ON:      lit_o = 1'b1;
            LED_BLINK:   lit_o = phase_q;
            LED_PWM:     lit_o = duty_lit(pwm_cnt_i, level_q);
            LED_BREATHE: lit_o = duty_lit(pwm_cnt_i, bright_q);
            default:     lit_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/led_status_ctrl.sv
// Multi-channel status-LED driver: shared tick prescaler and PWM counter, config decode, registered LED outputs.
module led_status_ctrl
    import led_pkg::*;
#(
    parameter int NUM_CH      = 3,
    parameter int CLK_HZ      = 48_000_000,
    parameter int TICK_HZ     = 1_000,
    parameter int PWM_BITS    = 8,
    parameter int PERIOD_BITS = 16,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic                   clk48,
    input  logic                   rst,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [3:0]             cfg_ch,
    input  logic [2:0]             cfg_mode,
    input  logic [PWM_BITS-1:0]    cfg_level,
    input  logic [PERIOD_BITS-1:0] cfg_half_per,
    output logic                   cfg_err,
    output logic                   tick,
    output logic [NUM_CH-1:0]      led
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

    logic [PRE_W-1:0]    pre_q, pre_d;
    logic                tick_q, tick_d;
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    logic                ready_q;
    logic                err_q, err_d;
    logic [NUM_CH-1:0]   led_q, led_d;
    logic [NUM_CH-1:0]   lit;
    logic                accept, ch_ok, mode_ok, wr_ok;

    always_comb begin
        accept  = cfg_valid & ready_q;
        ch_ok   = ({28'd0, cfg_ch} < 32'(NUM_CH));
        mode_ok = (cfg_mode <= LED_MODE_MAX);
        wr_ok   = accept & ch_ok & mode_ok;
        err_d   = accept & ~(ch_ok & mode_ok);
        tick_d  = (pre_q == PRE_LAST);
        pre_d   = tick_d ? '0 : pre_q + PRE_W'(1);
        pwm_d   = pwm_q + PWM_BITS'(1);
        led_d   = lit ^ {NUM_CH{ACTIVE_LOW}};
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        led_channel #(
            .PWM_BITS    (PWM_BITS),
            .PERIOD_BITS (PERIOD_BITS)
        ) u_ch (
            .clk48      (clk48),
            .rst        (rst),
            .we_i       (wr_ok && (cfg_ch == 4'(i))),
            .tick_i     (tick_q),
            .mode_i     (led_mode_t'(cfg_mode)),
            .level_i    (cfg_level),
            .half_per_i (cfg_half_per),
            .pwm_cnt_i  (pwm_q),
            .lit_o      (lit[i])
        );
    end

    always_ff @(posedge clk48) begin
        if (rst) begin
            pre_q   <= '0;
            tick_q  <= 1'b0;
            pwm_q   <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            led_q   <= {NUM_CH{ACTIVE_LOW}};
        end else begin
            pre_q   <= pre_d;
            tick_q  <= tick_d;
            pwm_q   <= pwm_d;
            ready_q <= 1'b1;
            err_q   <= err_d;
            led_q   <= led_d;
        end
    end

    assign cfg_ready = ready_q;
    assign cfg_err   = err_q;
    assign tick      = tick_q;
    assign led       = led_q;

endmodule

// File: tb/tb_led_status_ctrl.sv
// Bench for led_status_ctrl: scenario tasks checked against a closed-form timing model of the LED outputs.
module tb_led_status_ctrl;

    localparam int NCH  = 3;
    localparam int DIV  = 10;
    localparam int PWMN = 16;

    logic        clk48 = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [3:0]  cfg_ch;
    logic [2:0]  cfg_mode;
    logic [3:0]  cfg_level;
    logic [15:0] cfg_half_per;
    logic        cfg_err;
    logic        tick;
    logic [2:0]  led;

    int n_chk  = 0;
    int n_fail = 0;

    // Model state: edge index since reset release, and the last accepted config per channel.
    int   m = -1;
    int   rec_mode[NCH];
    int   rec_level[NCH];
    int   rec_half[NCH];
    int   rec_acc[NCH];
    logic [2:0] exp_led;
    logic exp_tick, exp_err, exp_ready;

    led_status_ctrl #(
        .NUM_CH(NCH), .CLK_HZ(1000), .TICK_HZ(100),
        .PWM_BITS(4), .PERIOD_BITS(16), .ACTIVE_LOW(1'b1)
    ) dut (
        .clk48(clk48), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_level(cfg_level),
        .cfg_half_per(cfg_half_per), .cfg_err(cfg_err), .tick(tick), .led(led)
    );

    always #5 clk48 = ~clk48;

    // Lit state seen after edge mm, from the accept edge and the number of ticks elapsed since it.
    function automatic bit model_lit(input int c, input int mm);
        int t, h, lv, p, br;
        lv = rec_level[c];
        t  = (mm - 1) / DIV - rec_acc[c] / DIV;
        case (rec_mode[c])
            1: return 1'b1;
            2: begin
                h = (rec_half[c] == 0) ? 1 : rec_half[c];
                return ((t / h) % 2) == 1;
            end
            3: return ((mm % PWMN) < lv) || (lv == PWMN - 1);
            4: begin
                if (lv == 0) return 1'b0;
                p  = t % (2 * lv);
                br = (p <= lv) ? p : 2 * lv - p;
                return ((mm % PWMN) < br) || (br == PWMN - 1);
            end
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            rec_mode[c] = 0; rec_level[c] = 0; rec_half[c] = 1; rec_acc[c] = 0;
        end
    endtask

    task automatic cyc();
        bit acc, bad;
        @(posedge clk48);
        if (rst) begin
            m = -1;
            model_reset();
            exp_led = 3'b111; exp_tick = 1'b0; exp_err = 1'b0; exp_ready = 1'b0;
        end else begin
            m++;
            for (int c = 0; c < NCH; c++) exp_led[c] = ~model_lit(c, m);
            acc       = cfg_valid && (m >= 1);
            bad       = (int'(cfg_ch) >= NCH) || (int'(cfg_mode) > 4);
            exp_err   = acc && bad;
            exp_tick  = (m % DIV) == DIV - 1;
            exp_ready = 1'b1;
            if (acc && !bad) begin
                rec_mode[cfg_ch]  = int'(cfg_mode);
                rec_level[cfg_ch] = int'(cfg_level);
                rec_half[cfg_ch]  = int'(cfg_half_per);
                rec_acc[cfg_ch]   = m;
            end
        end
        #1;
    endtask

    task automatic cfg_write(input int ch, input int mode, input int lvl, input int half);
        cfg_valid    = 1'b1;
        cfg_ch       = 4'(ch);
        cfg_mode     = 3'(mode);
        cfg_level    = 4'(lvl);
        cfg_half_per = 16'(half);
        cyc();
        cfg_valid    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        n_chk++;
        if (led !== 3'b111) begin n_fail++; $display("FAIL reset_led got=%b want=111", led); end
        n_chk++;
        if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b want=0", cfg_ready); end
        n_chk++;
        if (tick !== 1'b0 || cfg_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_tick_err tick=%b err=%b want 0/0", tick, cfg_err);
        end
        rst = 1'b0;
        cyc();
        n_chk++;
        if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready got=%b want=1", cfg_ready); end
    endtask

    task automatic test_on_off();
        cfg_write(1, 1, 0, 0);
        n_chk++;
        if (led[1] !== 1'b1) begin n_fail++; $display("FAIL on_early got=%b want=1", led[1]); end
        cyc();
        n_chk++;
        if (led[1] !== 1'b0) begin n_fail++; $display("FAIL on_lat2 got=%b want=0", led[1]); end
        for (int i = 0; i < 5; i++) cyc();
        cfg_write(1, 0, 0, 0);
        cyc();
        n_chk++;
        if (led[1] !== 1'b1) begin n_fail++; $display("FAIL off_lat2 got=%b want=1", led[1]); end
    endtask

    task automatic test_blink();
        int last_chg, n_chg;
        logic prev;
        cfg_write(0, 2, 0, 3);
        prev = led[0]; last_chg = m; n_chg = 0;
        for (int i = 0; i < 130; i++) begin
            cyc();
            n_chk++;
            if (led !== exp_led) begin n_fail++; $display("FAIL blink3 led=%b want=%b m=%0d", led, exp_led, m); end
            if (led[0] !== prev) begin
                if (n_chg > 0) begin
                    n_chk++;
                    if (m - last_chg != 30) begin
                        n_fail++; $display("FAIL blink_period got=%0d want=30", m - last_chg);
                    end
                end
                n_chg++; last_chg = m; prev = led[0];
            end
        end
        n_chk++;
        if (n_chg < 3) begin n_fail++; $display("FAIL blink_toggles got=%0d want>=3", n_chg); end
        cfg_write(0, 2, 0, 0);
        for (int i = 0; i < 45; i++) begin
            cyc();
            n_chk++;
            if (led !== exp_led) begin n_fail++; $display("FAIL blink0 led=%b want=%b m=%0d", led, exp_led, m); end
        end
    endtask

    task automatic test_pwm();
        int levels[3] = '{4, 0, 15};
        int lit_cnt, want;
        for (int k = 0; k < 3; k++) begin
            cfg_write(2, 3, levels[k], 0);
            cyc();
            lit_cnt = 0;
            for (int i = 0; i < PWMN; i++) begin
                cyc();
                if (led[2] === 1'b0) lit_cnt++;
                n_chk++;
                if (led !== exp_led) begin n_fail++; $display("FAIL pwm led=%b want=%b m=%0d", led, exp_led, m); end
            end
            want = (levels[k] == 15) ? 16 : levels[k];
            n_chk++;
            if (lit_cnt != want) begin
                n_fail++; $display("FAIL pwm_duty lvl=%0d got=%0d want=%0d", levels[k], lit_cnt, want);
            end
        end
    endtask

    task automatic test_breathe();
        cfg_write(2, 0, 0, 0);
        cfg_write(0, 4, 3, 0);
        for (int i = 0; i < 90; i++) begin
            cyc();
            n_chk++;
            if (led !== exp_led) begin n_fail++; $display("FAIL breathe led=%b want=%b m=%0d", led, exp_led, m); end
        end
        cfg_write(0, 4, 0, 0);
        for (int i = 0; i < 30; i++) begin
            cyc();
            n_chk++;
            if (led[0] !== 1'b1) begin n_fail++; $display("FAIL breathe_lvl0 got=%b want=1", led[0]); end
        end
    endtask

    task automatic test_errors();
        logic [2:0] snap;
        cfg_write(1, 1, 0, 0);
        cyc(); cyc();
        snap = led;
        cfg_write(5, 1, 7, 2);
        n_chk++;
        if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL err_ch got=%b want=1", cfg_err); end
        cfg_write(1, 6, 7, 2);
        n_chk++;
        if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL err_mode got=%b want=1", cfg_err); end
        cyc();
        n_chk++;
        if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL err_pulse got=%b want=0", cfg_err); end
        cyc();
        n_chk++;
        if (led !== snap) begin n_fail++; $display("FAIL err_led got=%b want=%b", led, snap); end
    endtask

    task automatic test_tick_write();
        int waited = 0;
        cfg_write(0, 2, 0, 2);
        for (int i = 0; i < 15; i++) cyc();
        while (tick !== 1'b1 && waited < 20) begin cyc(); waited++; end
        n_chk++;
        if (tick !== 1'b1) begin n_fail++; $display("FAIL tick_wait got=%b want=1", tick); end
        cfg_write(0, 2, 0, 2);
        for (int i = 0; i < 70; i++) begin
            cyc();
            n_chk++;
            if (led !== exp_led) begin n_fail++; $display("FAIL tick_write led=%b want=%b m=%0d", led, exp_led, m); end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            cfg_write($urandom_range(3, 0), $urandom_range(5, 0), $urandom_range(15, 0), $urandom_range(3, 0));
            for (int i = 0; i < int'($urandom_range(25, 1)); i++) begin
                cfg_ch = 4'($urandom_range(15, 0));
                cfg_mode = 3'($urandom_range(7, 0));
                cyc();
                n_chk++;
                if (led !== exp_led || tick !== exp_tick || cfg_err !== exp_err || cfg_ready !== exp_ready) begin
                    n_fail++;
                    $display("FAIL random led=%b/%b tick=%b/%b err=%b/%b rdy=%b/%b m=%0d",
                             led, exp_led, tick, exp_tick, cfg_err, exp_err, cfg_ready, exp_ready, m);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        cfg_write(0, 2, 0, 1);
        cfg_write(1, 1, 0, 0);
        for (int i = 0; i < 25; i++) cyc();
        rst = 1'b1;
        cfg_valid = 1'b1; cfg_ch = 4'd2; cfg_mode = 3'd1;
        cyc();
        cfg_valid = 1'b0;
        n_chk++;
        if (led !== 3'b111) begin n_fail++; $display("FAIL rst_mid_led got=%b want=111", led); end
        n_chk++;
        if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ready got=%b want=0", cfg_ready); end
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            n_chk++;
            if (led !== 3'b111) begin n_fail++; $display("FAIL rst_mid_off got=%b want=111", led); end
        end
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_mode = '0; cfg_level = '0; cfg_half_per = '0;
        model_reset();
        test_reset();
        test_on_off();
        test_blink();
        test_pwm();
        test_breathe();
        test_errors();
        test_tick_write();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
